fpadd_master: RTL and testbench
===============================

FPADD_MASTER -- requirements
Module: fpadd_master

Interface
REQ-001 Parameter: POLL_LIMIT, 16, max result-read attempts before error (1..255).
REQ-002 Parameter: RESP_WINDOW, 2, cycles to wait for readdatavalid after an accepted read (1..15).
REQ-003 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  command strobe; operands sampled in the same cycle.
REQ-006 opa  in  32  IEEE-754 single operand A.
REQ-007 opb  in  32  IEEE-754 single operand B.
REQ-008 busy  out  1  command in progress.
REQ-009 done  out  1  one-cycle pulse; result valid.
REQ-010 error  out  1  one-cycle pulse; poll limit exhausted.
REQ-011 result  out  32  last sum returned by slave.
REQ-012 masteraddress  out  3  Avalon-MM word address to accelerator slave.
REQ-013 masterread  out  1  Avalon-MM read.
REQ-014 masterwrite  out  1  Avalon-MM write.
REQ-015 masterwritedata  out  32  write data.
REQ-016 masterreaddata  in  32  read data.
REQ-017 masterreaddatavalid  in  1  read data valid.
REQ-018 masterwaitrequest  in  1  slave stall.

Function
REQ-019 FSM states SHALL be IDLE, WR_A, WR_B, RD_REQ, RD_WAIT, FIN.
REQ-020 IDLE: start=1 SHALL latch opa/opb, clear poll counter, go WR_A; start while busy SHALL be ignored.
REQ-021 WR_A SHALL drive masterwrite=1, address 3'h2, data=latched opa; advance to WR_B only in a cycle with masterwaitrequest=0.
REQ-022 WR_B SHALL drive masterwrite=1, address 3'h3, data=latched opb; advance to RD_REQ when masterwaitrequest=0 (this write triggers the slave addition).
REQ-023 RD_REQ SHALL drive masterread=1, address 3'h4; on masterwaitrequest=0 increment poll counter, clear window counter, go RD_WAIT.
REQ-024 Address, data, read and write SHALL stay stable while masterwaitrequest=1; read and write SHALL never be high together.
REQ-025 RD_WAIT: masterread=0; masterreaddatavalid=1 SHALL capture masterreaddata into result and go FIN.
REQ-026 RD_WAIT: no valid within RESP_WINDOW cycles SHALL go RD_REQ if poll counter < POLL_LIMIT, else pulse error and go IDLE; result unchanged on error.
REQ-027 readdatavalid arriving in the same cycle the window expires SHALL count as success.
REQ-028 FIN SHALL pulse done for exactly one cycle and return to IDLE; start in FIN SHALL be ignored.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 readdatavalid outside RD_WAIT SHALL be ignored.
REQ-031 Latency, waitrequest=0, first poll valid: start in cycle N -> writes cycles N+1, N+2, read N+3, valid N+4, done N+5.
REQ-032 No arithmetic besides counters; counters saturate-free, widths sized to parameters.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE; busy, done, error, masterread, masterwrite=0; masteraddress=3'h0, masterwritedata=0, result=0, counters=0.
REQ-034 Reset mid-transaction SHALL abandon the transfer with no done/error pulse; first start after release SHALL run normally.

Verification
REQ-035 opa=0x3F800000, opb=0x40000000, no stalls, slave valid on first poll with 0x40400000 -> writes addr2/addr3 in N+1/N+2, read N+3, done and result=0x40400000 in N+5.
REQ-036 masterwaitrequest=1 for 3 cycles during WR_B -> address 3'h3/data held stable 4 cycles, one write accepted, done delayed 3 cycles.
REQ-037 Slave withholds valid for first 2 polls, returns 0x40A00000 on 3rd -> exactly 3 accepted reads, result=0x40A00000, one done pulse.
REQ-038 Slave never valid, POLL_LIMIT=16 -> 16 accepted reads, single error pulse, result keeps prior value, busy=0.
REQ-039 start held high continuously -> one command per IDLE pass; no start accepted while busy.
REQ-040 reset_n low during RD_WAIT -> all outputs reset value immediately; no done/error; next command completes.

Source files
------------

// File: rtl/fpadd_master.sv
// fpadd_master: Avalon-MM master that writes two float operands to an adder slave,
// then polls its result register with a bounded response window and poll budget.
module fpadd_master #(
  parameter int POLL_LIMIT  = 16,
  parameter int RESP_WINDOW = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic [2:0]  masteraddress,
  output logic        masterread,
  output logic        masterwrite,
  output logic [31:0] masterwritedata,
  input  logic [31:0] masterreaddata,
  input  logic        masterreaddatavalid,
  input  logic        masterwaitrequest
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int WW = $clog2(RESP_WINDOW + 1);
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_REQ, RD_WAIT, FIN} state_t;
  state_t        r_state;
  logic [31:0]   r_opb, r_result, r_wdata;
  logic [PW-1:0] r_poll;
  logic [WW-1:0] r_win;
  logic [2:0]    r_addr;
  logic          r_busy, r_done, r_error, r_rd, r_wr;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign result          = r_result;
  assign masteraddress   = r_addr;
  assign masterread      = r_rd;
  assign masterwrite     = r_wr;
  assign masterwritedata = r_wdata;
  // Bus outputs are registered and only change on an accepted transfer, so they hold under waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_opb    <= '0;
      r_result <= '0;
      r_wdata  <= '0;
      r_poll   <= '0;
      r_win    <= '0;
      r_addr   <= 3'h0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_opb   <= opb;
          r_wdata <= opa;
          r_poll  <= '0;
          r_addr  <= 3'h2;
          r_wr    <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= WR_A;
        end
        WR_A: if (!masterwaitrequest) begin
          r_wdata <= r_opb;
          r_addr  <= 3'h3;
          r_state <= WR_B;
        end
        WR_B: if (!masterwaitrequest) begin
          r_wr    <= 1'b0;
          r_rd    <= 1'b1;
          r_addr  <= 3'h4;
          r_state <= RD_REQ;
        end
        RD_REQ: if (!masterwaitrequest) begin
          r_rd    <= 1'b0;
          r_poll  <= r_poll + 1'b1;
          r_win   <= '0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: if (masterreaddatavalid) begin
          r_result <= masterreaddata;
          r_done   <= 1'b1;
          r_state  <= FIN;
        end else if (r_win == WW'(RESP_WINDOW - 1)) begin
          if (r_poll < PW'(POLL_LIMIT)) begin
            r_rd    <= 1'b1;
            r_state <= RD_REQ;
          end else begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end else begin
          r_win <= r_win + 1'b1;
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpadd_master.sv
// tb_fpadd_master: table-driven and randomized transactions against a behavioural Avalon slave
// whose latency, poll count and result expectations come from a timing-budget model.
module tb_fpadd_master;
  localparam int PL = 16;
  localparam int RW = 2;
  logic        clk = 0, reset_n = 1, start = 0;
  logic [31:0] opa = 0, opb = 0, mrd = 0;
  logic        mrdv = 0, mwait = 0;
  logic        busy, done, error, masterread, masterwrite;
  logic [31:0] result, masterwritedata;
  logic [2:0]  masteraddress;
  int          cyc = 0, checks = 0, errors = 0;
  logic [31:0] last_res = 0;

  typedef struct {
    logic [31:0] a, b;
    int          sa, sb, sr, fails, d;
    logic [31:0] rd;
    int          e_lat, e_rd;
    bit          e_err;
    logic [31:0] e_res;
  } vec_t;
  vec_t tbl[6];

  fpadd_master #(.POLL_LIMIT(PL), .RESP_WINDOW(RW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .error(error), .result(result),
    .masteraddress(masteraddress), .masterread(masterread), .masterwrite(masterwrite),
    .masterwritedata(masterwritedata), .masterreaddata(mrd),
    .masterreaddatavalid(mrdv), .masterwaitrequest(mwait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle budget: issue cycle, each phase's cycles incl. stalls, each failed poll's full window.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int base = 1 + (1 + v.sa) + (1 + v.sb);
    r.e_err = v.fails >= PL;
    r.e_rd  = r.e_err ? PL : v.fails + 1;
    r.e_lat = r.e_err ? base + PL * (1 + v.sr + RW) : base + v.fails * (1 + v.sr + RW) + 1 + v.sr + v.d;
    r.e_res = r.e_err ? last_res : v.rd;
    return r;
  endfunction

  // Entered at a negedge with the DUT idle; leaves at the negedge of the following idle cycle.
  task automatic run_txn(input vec_t v, input bit hold);
    int n = cyc, ra = v.sa, rb = v.sb, rr = v.sr, wa = 0, wb = 0, nrd = 0;
    int nd = 0, ne = 0, lat = -1, vcyc = -1, excl = 0, stab = 0, badaddr = 0;
    bit w, pw = 0, fin = 0;
    logic [2:0] pa = 0;
    logic pr = 0, pwr = 0;
    logic [31:0] pd = 0;
    chk("idle_busy", busy, 0);
    opa = v.a; opb = v.b; start = 1;
    for (int k = 0; k < 600 && !fin; k++) begin
      @(posedge clk); @(negedge clk);
      if (!hold) start = 0;
      if (done) begin nd++; lat = cyc - n; fin = 1; end
      if (error) begin ne++; lat = cyc - n; fin = 1; end
      if (masterread && masterwrite) excl++;
      if (pw && ({masteraddress, masterread, masterwrite} != {pa, pr, pwr} ||
                 (masterwrite && masterwritedata != pd))) stab++;
      w = 0; mrdv = 0; mrd = $urandom;
      if (masterwrite) begin
        if (masteraddress == 3'h2 && ra > 0) begin w = 1; ra--; end
        else if (masteraddress == 3'h3 && rb > 0) begin w = 1; rb--; end
        else if (masteraddress == 3'h2) begin wa++; chk("wr_a_data", masterwritedata, v.a); end
        else if (masteraddress == 3'h3) begin wb++; chk("wr_b_data", masterwritedata, v.b); end
        else badaddr++;
      end
      if (masterread) begin
        if (masteraddress != 3'h4) badaddr++;
        if (rr > 0) begin w = 1; rr--; end
        else begin nrd++; rr = v.sr; if (nrd > v.fails) vcyc = cyc + v.d; end
      end
      if (cyc == vcyc) begin mrdv = 1; mrd = v.rd; end
      else if ((masterread || masterwrite) && $urandom_range(1) == 1) mrdv = 1;
      pw = w; pa = masteraddress; pr = masterread; pwr = masterwrite; pd = masterwritedata;
      mwait = w;
    end
    mwait = 0; mrdv = 0;
    @(posedge clk); @(negedge clk);
    chk("complete", 32'(fin), 1);
    chk("done_one_cycle", done, 0);
    chk("error_one_cycle", error, 0);
    chk("busy_after", busy, 0);
    chk("latency", 32'(lat), 32'(v.e_lat));
    chk("reads", 32'(nrd), 32'(v.e_rd));
    chk("done_cnt", 32'(nd), 32'(!v.e_err));
    chk("error_cnt", 32'(ne), 32'(v.e_err));
    chk("wr_a_cnt", 32'(wa), 1);
    chk("wr_b_cnt", 32'(wb), 1);
    chk("rd_wr_excl", 32'(excl), 0);
    chk("stable_stall", 32'(stab), 0);
    chk("bad_addr", 32'(badaddr), 0);
    chk("result", result, v.e_res);
    last_res = v.e_res;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
    chk({nm, "_read"}, masterread, 0);
    chk({nm, "_write"}, masterwrite, 0);
    chk({nm, "_addr"}, 32'(masteraddress), 0);
    chk({nm, "_wdata"}, masterwritedata, 0);
    chk({nm, "_result"}, result, 0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{32'h3F800000, 32'h40000000, 0, 0, 0, 0, 1, 32'h40400000, 5, 1, 1'b0, 32'h40400000};
    tbl[1] = '{32'h3F800000, 32'h40000000, 0, 3, 0, 0, 1, 32'h40400000, 8, 1, 1'b0, 32'h40400000};
    tbl[2] = '{32'h40000000, 32'h40400000, 0, 0, 0, 2, 1, 32'h40A00000, 11, 3, 1'b0, 32'h40A00000};
    tbl[3] = '{32'h11111111, 32'h22222222, 0, 0, 0, 255, 1, 32'hDEADBEEF, 51, 16, 1'b1, 32'h40A00000};
    tbl[4] = '{32'h3F000000, 32'hBF000000, 0, 0, 0, 0, 2, 32'h12345678, 6, 1, 1'b0, 32'h12345678};
    tbl[5] = '{32'h41200000, 32'hC1A00000, 2, 0, 1, 1, 2, 32'hC0000000, 13, 2, 1'b0, 32'hC0000000};
    #1 reset_n = 0;
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_txn(tbl[i], 0);
    run_txn(tbl[0], 1);
    run_txn(tbl[4], 0);
    for (int i = 0; i < 24; i++) begin
      v.a = $urandom; v.b = $urandom; v.rd = $urandom;
      v.sa = $urandom_range(3); v.sb = $urandom_range(3); v.sr = $urandom_range(2);
      v.fails = ($urandom_range(7) == 0) ? PL + $urandom_range(3) : $urandom_range(3);
      v.d = $urandom_range(RW, 1);
      run_txn(model(v), 0);
    end
    opa = 32'h3F800000; opb = 32'h3F800000; start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("rdwait_busy", busy, 1);
    chk("rdwait_read", masterread, 0);
    #2 reset_n = 0;
    #1 chk_reset("async");
    repeat (2) @(negedge clk);
    chk("rst_hold_done", done, 0);
    chk("rst_hold_error", error, 0);
    reset_n = 1;
    last_res = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_result", result, 0);
    v = '{32'h40400000, 32'h40800000, 0, 0, 0, 0, 1, 32'h40E00000, 0, 0, 1'b0, 32'h0};
    run_txn(model(v), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
